// File: rtl/mc_dbg_pkg.sv
// Shared encodings for the multi-cycle computer's run-control and debug unit.
package mc_dbg_pkg;

    // Debug command opcodes carried on cmd_op.
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_RUN     = 3'd1;
    localparam logic [2:0] OP_HALT    = 3'd2;
    localparam logic [2:0] OP_STEP    = 3'd3;
    localparam logic [2:0] OP_SET_BP  = 3'd4;
    localparam logic [2:0] OP_CLR_BP  = 3'd5;
    localparam logic [2:0] OP_CLR_CNT = 3'd6;

    // Controller FSM encoding of the fetch state, shared with the core controller.
    localparam logic [3:0] FETCH_STATE_DEFAULT = 4'd0;

    // Run-control state.
    typedef enum logic [1:0] {
        RS_HALTED   = 2'd0,
        RS_RUNNING  = 2'd1,
        RS_STEPPING = 2'd2
    } run_state_t;

    // Breakpoint index width; a single slot still needs one index bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mc_bp_match.sv
// Breakpoint slot registers plus a comparator array with lowest-index priority.
module mc_bp_match
    import mc_dbg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NUM_BP = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_set,
    input  logic              wr_clr,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              match,
    output logic [IDX_W-1:0]  match_idx
);

    logic [ADDR_W-1:0] bp_addr [NUM_BP];
    logic [NUM_BP-1:0] bp_en;

    // Slot writes land next cycle; an index beyond NUM_BP selects no slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_en <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    if (wr_set) begin
                        bp_addr[i] <= wr_addr;
                        bp_en[i]   <= 1'b1;
                    end else if (wr_clr) begin
                        bp_en[i]   <= 1'b0;
                    end
                end
            end
        end
    end

    // Scan from the top slot down so the lowest matching slot is left in match_idx.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && (bp_addr[i] == fetch_pc)) begin
                match     = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mc_run_control.sv
// Run-control and debug unit: gates the core clock enable for halt, run,
// single-instruction step and PC breakpoints, and counts instructions and cycles.
// Command interface: cmd_valid is a strobe with no back-pressure; every command
// presented with cmd_valid=1 is consumed at that clock edge and its effect is
// visible from the next cycle.
module mc_run_control
    import mc_dbg_pkg::*;
#(
    parameter int         ADDR_W        = 32,
    parameter int         NUM_BP        = 4,
    parameter int         CNT_W         = 32,
    parameter logic [3:0] FETCH_STATE   = FETCH_STATE_DEFAULT,
    parameter bit         START_RUNNING = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             fetch_pc,
    input  logic [3:0]                    fsm_state,
    input  logic                          cmd_valid,
    input  logic [2:0]                    cmd_op,
    input  logic [idx_width(NUM_BP)-1:0]  cmd_idx,
    input  logic [ADDR_W-1:0]             cmd_addr,
    output logic                          core_en,
    output logic                          halted,
    output logic                          bp_hit,
    output logic [idx_width(NUM_BP)-1:0]  bp_idx,
    output logic [CNT_W-1:0]              instr_count,
    output logic [CNT_W-1:0]              cycle_count
);

    localparam int         IDX_W       = idx_width(NUM_BP);
    localparam run_state_t RESET_STATE = START_RUNNING ? RS_RUNNING : RS_HALTED;

    run_state_t       state_q, state_d;
    logic             skip_q, skip_d;
    logic             halt_pend_q, halt_pend_d;
    logic             fetched_q, fetched_d;
    logic             bp_hit_q, bp_hit_d;
    logic [IDX_W-1:0] bp_idx_q, bp_idx_d;

    logic             at_fetch;
    logic             raw_match;
    logic [IDX_W-1:0] match_idx;
    logic             bp_take;
    logic             cmd_run, cmd_halt, cmd_step, cmd_clr_cnt;

    assign at_fetch    = (fsm_state == FETCH_STATE);
    assign cmd_run     = cmd_valid && (cmd_op == OP_RUN);
    assign cmd_halt    = cmd_valid && (cmd_op == OP_HALT);
    assign cmd_step    = cmd_valid && (cmd_op == OP_STEP);
    assign cmd_clr_cnt = cmd_valid && (cmd_op == OP_CLR_CNT);

    mc_bp_match #(
        .ADDR_W (ADDR_W),
        .NUM_BP (NUM_BP),
        .IDX_W  (IDX_W)
    ) u_bp_match (
        .clk       (clk),
        .reset     (reset),
        .wr_set    (cmd_valid && (cmd_op == OP_SET_BP)),
        .wr_clr    (cmd_valid && (cmd_op == OP_CLR_BP)),
        .wr_idx    (cmd_idx),
        .wr_addr   (cmd_addr),
        .fetch_pc  (fetch_pc),
        .match     (raw_match),
        .match_idx (match_idx)
    );

    // A breakpoint only counts at a boundary, and not on the first fetch after a resume.
    assign bp_take = at_fetch && raw_match && !skip_q;

    // Run-control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            skip_q      <= 1'b1;
            halt_pend_q <= 1'b0;
            fetched_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
            bp_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            halt_pend_q <= halt_pend_d;
            fetched_q   <= fetched_d;
            bp_hit_q    <= bp_hit_d;
            bp_idx_q    <= bp_idx_d;
        end
    end

    // Next-state and core enable; halts only ever happen at an instruction boundary.
    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        halt_pend_d = halt_pend_q;
        fetched_d   = fetched_q;
        bp_hit_d    = bp_hit_q;
        bp_idx_d    = bp_idx_q;
        core_en     = 1'b0;
        case (state_q)
            RS_RUNNING: begin
                core_en = !(bp_take || (at_fetch && halt_pend_q));
                if (!core_en) begin
                    state_d     = RS_HALTED;
                    halt_pend_d = 1'b0;
                    if (bp_take) begin
                        bp_hit_d = 1'b1;
                        bp_idx_d = match_idx;
                    end
                end else if (cmd_halt) begin
                    halt_pend_d = 1'b1;
                end
            end
            RS_STEPPING: begin
                core_en = !(fetched_q && at_fetch);
                if (!core_en) begin
                    state_d     = RS_HALTED;
                    halt_pend_d = 1'b0;
                end else if (at_fetch) begin
                    fetched_d = 1'b1;
                end
            end
            RS_HALTED: begin
                if (cmd_run) begin
                    state_d  = RS_RUNNING;
                    skip_d   = 1'b1;
                    bp_hit_d = 1'b0;
                end else if (cmd_step) begin
                    state_d   = RS_STEPPING;
                    skip_d    = 1'b1;
                    fetched_d = 1'b0;
                    bp_hit_d  = 1'b0;
                end
            end
            default: begin
                state_d = RS_HALTED;
            end
        endcase
        if (core_en && at_fetch) begin
            skip_d = 1'b0;
        end
    end

    // Instruction and cycle counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
            cycle_count <= '0;
        end else if (cmd_clr_cnt) begin
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            if (core_en) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (core_en && at_fetch) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    assign halted = (state_q == RS_HALTED);
    assign bp_hit = bp_hit_q;
    assign bp_idx = bp_idx_q;

endmodule

// File: tb/tb_mc_run_control.sv
// Bench for mc_run_control: a small multi-cycle core model driven by core_en,
// directed scenarios plus randomized commands against a behavioural model.
module tb_mc_run_control;
  import mc_dbg_pkg::*;

  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic [3:0]  fsm_state;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_idx;
  logic [31:0] cmd_addr;
  logic        core_en;
  logic        halted;
  logic        bp_hit;
  logic [1:0]  bp_idx;
  logic [CW-1:0] instr_count;
  logic [CW-1:0] cycle_count;

  int n_tests;
  int n_fail;
  bit last_en;

  // behavioural model state
  bit          m_run, m_step, m_skip, m_pend, m_fetched, m_hit;
  logic [1:0]  m_idx;
  logic [31:0] m_bpa [4];
  bit          m_bpon [4];
  logic [CW-1:0] m_ic, m_cc;

  mc_run_control #(
    .ADDR_W(32), .NUM_BP(4), .CNT_W(CW), .FETCH_STATE(4'd0), .START_RUNNING(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .fsm_state(fsm_state),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_addr(cmd_addr),
    .core_en(core_en), .halted(halted), .bp_hit(bp_hit), .bp_idx(bp_idx),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // instruction length in core states: 0x14 is a 4-state instruction, all others 3
  function automatic int ilen(input logic [31:0] pc);
    return (pc == 32'h14) ? 4 : 3;
  endfunction

  function automatic bit m_halted();
    return !m_run && !m_step;
  endfunction

  function automatic int lowest_hit();
    if (fsm_state != 4'd0) return -1;
    for (int i = 0; i < 4; i++)
      if (m_bpon[i] && m_bpa[i] == fetch_pc) return i;
    return -1;
  endfunction

  function automatic bit m_en();
    bit at;
    at = (fsm_state == 4'd0);
    if (m_run)  return !(at && ((lowest_hit() >= 0 && !m_skip) || m_pend));
    if (m_step) return !(at && m_fetched);
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_run = 1; m_step = 0; m_skip = 1; m_pend = 0; m_fetched = 0;
    m_hit = 0; m_idx = 0; m_ic = 0; m_cc = 0;
    for (int i = 0; i < 4; i++) begin
      m_bpon[i] = 0;
      m_bpa[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [2:0] op, input logic [1:0] idx, input logic [31:0] addr);
    bit en, at;
    int hit;
    en = m_en();
    at = (fsm_state == 4'd0);
    hit = lowest_hit();
    if (op == OP_CLR_CNT) begin
      m_ic = 0; m_cc = 0;
    end else begin
      if (en) m_cc = m_cc + 1'b1;
      if (en && at) m_ic = m_ic + 1'b1;
    end
    if (m_run) begin
      if (!en) begin
        m_run = 0; m_pend = 0;
        if (hit >= 0 && !m_skip) begin
          m_hit = 1; m_idx = 2'(hit);
        end
      end else begin
        if (op == OP_HALT) m_pend = 1;
        if (at) m_skip = 0;
      end
    end else if (m_step) begin
      if (!en) begin
        m_step = 0; m_pend = 0;
      end else if (at) begin
        m_fetched = 1; m_skip = 0;
      end
    end else begin
      if (op == OP_RUN) begin
        m_run = 1; m_skip = 1; m_hit = 0;
      end else if (op == OP_STEP) begin
        m_step = 1; m_fetched = 0; m_skip = 1; m_hit = 0;
      end
    end
    if (op == OP_SET_BP) begin
      m_bpa[idx] = addr; m_bpon[idx] = 1;
    end else if (op == OP_CLR_BP) begin
      m_bpon[idx] = 0;
    end
  endtask

  task automatic core_advance(input bit en);
    if (en) begin
      if (int'(fsm_state) == ilen(fetch_pc) - 1) begin
        fsm_state = 4'd0;
        fetch_pc = (fetch_pc + 32'd4) & 32'h3C;
      end else begin
        fsm_state = fsm_state + 4'd1;
      end
    end
  endtask

  // one clock cycle: drive command, check outputs at negedge, update model and core at posedge
  task automatic cyc(input bit v, input logic [2:0] op, input logic [1:0] idx, input logic [31:0] addr);
    bit en;
    cmd_valid = v; cmd_op = op; cmd_idx = idx; cmd_addr = addr;
    @(negedge clk);
    en = m_en();
    chk("core_en", {31'd0, core_en}, {31'd0, en});
    chk("halted", {31'd0, halted}, {31'd0, m_halted()});
    chk("bp_hit", {31'd0, bp_hit}, {31'd0, m_hit});
    chk("bp_idx", {30'd0, bp_idx}, {30'd0, m_idx});
    chk("instr_count", {24'd0, instr_count}, {24'd0, m_ic});
    chk("cycle_count", {24'd0, cycle_count}, {24'd0, m_cc});
    last_en = core_en;
    @(posedge clk);
    model_edge(v ? op : OP_NOP, idx, addr);
    #1;
    core_advance(en);
    cmd_valid = 0; cmd_op = OP_NOP;
  endtask

  initial begin
    int guard;
    int n_hi;
    int r;
    bit at10;
    bit hit_seen;
    logic [CW-1:0] ic0;
    n_tests = 0; n_fail = 0;
    cmd_valid = 0; cmd_op = OP_NOP; cmd_idx = 0; cmd_addr = 0;
    fetch_pc = 0; fsm_state = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_en", {31'd0, core_en}, 32'd1);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    chk("rst_bp_idx", {30'd0, bp_idx}, 32'd0);
    chk("rst_instr", {24'd0, instr_count}, 32'd0);
    chk("rst_cycle", {24'd0, cycle_count}, 32'd0);
    reset = 0;

    // free run 30 cycles
    repeat (30) cyc(0, OP_NOP, 0, 0);
    #3;
    chk("run30_cycle", {24'd0, cycle_count}, 32'd30);
    chk("run30_instr", {24'd0, instr_count}, 32'd10);

    // breakpoint at 0x10 in slot 2
    cyc(1, OP_SET_BP, 2'd2, 32'h10);
    hit_seen = 0;
    guard = 0;
    while (!m_halted() && guard < 200) begin
      at10 = (fsm_state == 4'd0) && (fetch_pc == 32'h10);
      cyc(0, OP_NOP, 0, 0);
      if (at10) begin
        chk("bp_fetch_en_low", {31'd0, last_en}, 32'd0);
        hit_seen = 1;
      end
      guard++;
    end
    chk("bp_reached", {31'd0, hit_seen}, 32'd1);
    #3;
    chk("bp_halted", {31'd0, halted}, 32'd1);
    chk("bp_hit_set", {31'd0, bp_hit}, 32'd1);
    chk("bp_idx_2", {30'd0, bp_idx}, 32'd2);

    // resume from breakpoint, then halt mid-instruction
    ic0 = instr_count;
    cyc(1, OP_RUN, 0, 0);
    cyc(0, OP_NOP, 0, 0);
    chk("resume_no_rehit", {31'd0, last_en}, 32'd1);
    cyc(1, OP_HALT, 0, 0);
    chk("halt_cmd_cycle_en", {31'd0, last_en}, 32'd1);
    cyc(0, OP_NOP, 0, 0);
    chk("halt_mid_en", {31'd0, last_en}, 32'd1);
    cyc(0, OP_NOP, 0, 0);
    chk("halt_boundary_en", {31'd0, last_en}, 32'd0);
    #3;
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_no_bp", {31'd0, bp_hit}, 32'd0);
    chk("resume_instr", {24'd0, instr_count}, {24'd0, ic0 + 8'd1});

    // single step over the 4-state instruction at 0x14
    ic0 = instr_count;
    cyc(1, OP_STEP, 0, 0);
    n_hi = 0;
    guard = 0;
    while (m_step && guard < 20) begin
      cyc(0, OP_NOP, 0, 0);
      if (last_en) n_hi++;
      guard++;
    end
    chk("step_en_cycles", n_hi, 32'd4);
    #3;
    chk("step_halted", {31'd0, halted}, 32'd1);
    chk("step_instr", {24'd0, instr_count}, {24'd0, ic0 + 8'd1});

    // randomized commands against the model
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      cyc(0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 15)) << 2);
      else if (r < 54) cyc(1, OP_RUN, 0, 0);
      else if (r < 59) cyc(1, OP_HALT, 0, 0);
      else if (r < 67) cyc(1, OP_STEP, 0, 0);
      else if (r < 77) cyc(1, OP_SET_BP, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 15)) << 2);
      else if (r < 85) cyc(1, OP_CLR_BP, 2'($urandom_range(0, 3)), 0);
      else if (r < 88) cyc(1, OP_CLR_CNT, 0, 0);
      else             cyc(1, ($urandom_range(0, 1) != 0) ? 3'd7 : OP_NOP, 0, 0);
    end

    // drive cycle_count to its maximum, then clear
    for (int i = 0; i < 4; i++) cyc(1, OP_CLR_BP, 2'(i), 0);
    guard = 0;
    while (m_cc != {CW{1'b1}} && guard < 1000) begin
      cyc(m_halted(), OP_RUN, 0, 0);
      guard++;
    end
    #3;
    chk("cnt_at_max", {24'd0, cycle_count}, 32'hFF);
    cyc(1, OP_CLR_CNT, 0, 0);
    #3;
    chk("clr_cycle", {24'd0, cycle_count}, 32'd0);
    chk("clr_instr", {24'd0, instr_count}, 32'd0);

    // reset asserted in the middle of a step
    cyc(1, OP_SET_BP, 2'd1, 32'h8);
    cyc(1, OP_HALT, 0, 0);
    guard = 0;
    while (!m_halted() && guard < 20) begin
      cyc(0, OP_NOP, 0, 0);
      guard++;
    end
    cyc(1, OP_STEP, 0, 0);
    cyc(0, OP_NOP, 0, 0);
    cyc(0, OP_NOP, 0, 0);
    reset = 1;
    #1;
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_core_en", {31'd0, core_en}, 32'd1);
    chk("rst2_bp_hit", {31'd0, bp_hit}, 32'd0);
    chk("rst2_bp_idx", {30'd0, bp_idx}, 32'd0);
    chk("rst2_instr", {24'd0, instr_count}, 32'd0);
    chk("rst2_cycle", {24'd0, cycle_count}, 32'd0);
    fetch_pc = 0; fsm_state = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    repeat (60) cyc(0, OP_NOP, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_run_control.md
# mc_run_control

Parametrised run-control and debug unit for the multi-cycle ARM computer. It gates the core's clock enable, giving the core halt, run, single-instruction step and PC breakpoints, and it keeps instruction and cycle counters. It sits beside the multi-cycle computer top and observes the core's fetch PC and FSM state. It returns a single enable that the core uses to qualify every state, PC, IR and register update.

## Interface
Parameters:
- ADDR_W, 32, width of fetch PC and breakpoint addresses
- NUM_BP, 4, number of breakpoint slots (1..16)
- CNT_W, 32, width of instruction and cycle counters
- FETCH_STATE, 4'd0, core fsm_state encoding of the fetch state
- START_RUNNING, 1, run-control state after reset (1 RUNNING, 0 HALTED)

Ports:
- clk, in, 1, system clock
- reset, in, 1, asynchronous, active-high reset
- fetch_pc, in, ADDR_W, core PC (valid as the fetch address when fsm_state==FETCH_STATE)
- fsm_state, in, 4, core controller state
- cmd_valid, in, 1, command strobe; every command is accepted in the cycle it is presented
- cmd_op, in, 3, 0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT
- cmd_idx, in, $clog2(NUM_BP) (min 1), breakpoint slot
- cmd_addr, in, ADDR_W, breakpoint address for SET_BP
- core_en, out, 1, core clock enable
- halted, out, 1, run-control state is HALTED
- bp_hit, out, 1, sticky flag: the last halt was caused by a breakpoint
- bp_idx, out, $clog2(NUM_BP), lowest matching slot at the hit
- instr_count, out, CNT_W, number of enabled fetch cycles
- cycle_count, out, CNT_W, number of core_en cycles

## Operation
- States: HALTED, RUNNING, STEPPING.
- at_fetch = (fsm_state==FETCH_STATE). A boundary is any cycle with at_fetch=1.
- Breakpoint match: an enabled slot with bp_addr==fetch_pc while at_fetch. skip is set on entry to RUNNING/STEPPING and cleared after the first enabled fetch cycle, so a resume from a breakpoint does not re-hit the same breakpoint.
- RUNNING:
  - core_en = !(at_fetch && ((match && !skip) || halt_pend)).
  - When that term is true, go to HALTED.
  - bp_hit is set only if match && !skip. bp_idx takes the lowest matching slot.
- STEPPING:
  - fetched is set on the first enabled fetch cycle.
  - core_en = !(fetched && at_fetch). When that term is true, go to HALTED.
  - Breakpoints are ignored in STEPPING.
- HALTED: core_en=0.
- RUN:
  - From HALTED: go to RUNNING, set skip, clear bp_hit.
  - Ignored in RUNNING and STEPPING.
- STEP:
  - From HALTED: go to STEPPING, clear fetched, clear bp_hit.
  - Ignored otherwise.
- HALT:
  - In RUNNING: set halt_pend. The core stops at the next boundary, never mid-instruction.
  - In STEPPING and HALTED: no effect.
  - halt_pend clears on entry to HALTED.
- SET_BP and CLR_BP write a slot (address plus enable, or enable cleared) in any state. The write takes effect from the next cycle.
- CLR_CNT zeroes both counters next cycle. A same-cycle increment is dropped.
- Counters wrap modulo 2^CNT_W.
  - instr_count increments on core_en && at_fetch.
  - cycle_count increments on core_en.

## Timing
- Reset values:
  - State is RUNNING if START_RUNNING, else HALTED.
  - core_en follows from the reset state.
  - halted = !START_RUNNING.
  - bp_hit=0, bp_idx=0, both counters 0, all slots disabled, skip=1, halt_pend=0, fetched=0.
- A command is sampled at edge k. The state change is visible from cycle k+1, and core_en reflects it combinationally in k+1.
- core_en is combinational from registered state and the core's registered fsm_state/fetch_pc. No loop exists through core_en.
- Breakpoint halt has zero latency: core_en is low in the matching fetch cycle, so the instruction at bp_addr is not fetched.
- Simultaneous breakpoint match and halt_pend in the same cycle: halt, with bp_hit=1.
- A RUN arriving in the same cycle as a halt transition is ignored, because the state is still RUNNING.
- Reset asserted mid-step or mid-instruction returns every register to its reset value immediately.

## Structure
- Package mc_dbg_pkg holds:
  - cmd_op encodings
  - run-state encoding
  - default FETCH_STATE constant (shared with the controller FSM encoding)
- Sub-module mc_bp_match:
  - Holds NUM_BP address/enable registers and the comparator array.
  - Provides a lowest-index priority encoder producing match and bp_idx.

## Test plan
- Reset with START_RUNNING=1 and a 3-state instruction loop: core_en=1 every cycle. After 30 cycles, cycle_count=30 and instr_count=10.
- SET_BP slot 2 at 0x0000_0010 while running: core_en drops in the cycle fetch_pc=0x10 and at_fetch. Then halted=1, bp_hit=1, bp_idx=2.
- RUN from that breakpoint: no immediate re-hit. The core executes 0x10, and instr_count advances by 1 on the 0x10 fetch.
- STEP while halted at PC=0x14 (a 4-state instruction): core_en is high for exactly 4 cycles. It halts with fetch_pc=0x18 at_fetch, and instr_count has increased by 1.
- HALT issued mid-instruction: core_en stays high until the next at_fetch, then halted=1 with bp_hit=0.
- CLR_CNT with counters at 2^CNT_W-1: both counters read 0 next cycle. Separately, reset asserted while in STEPPING gives all reset values in the same cycle.
